demux_1to32_seq: RTL and testbench

// - Upstream driver stage for the 1-to-32 demux. Accepts one 32-bit word per

---
 rtl/demux_1to32_seq.sv | 129 ++++++++++++
 tb/tb_demux_1to32_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to32_seq.sv
// Serialiser feeding a 1-to-N_CH demux: one accepted word is spread one bit per channel per clock.
// Optional macro DEMUX_1TO32_SEQ_MASK_EN adds mask_i to gate en_o/data_o per channel.
module demux_1to32_seq #(
   parameter int N_CH      = 32,
   parameter int SEL_W     = 5,
   parameter int MSB_FIRST = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_CH-1:0]  word_i,
`ifdef DEMUX_1TO32_SEQ_MASK_EN
   input  logic [N_CH-1:0]  mask_i,
`endif
   input  logic             valid_i,
   output logic             ready_o,
   output logic             data_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             en_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic {IDLE, SEND} state_e;
   localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0]  shreg_q, shreg_d;
   logic             data_q, data_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             en_q, en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [N_CH-1:0]  src_w;
   logic             accept, go, bit_w, bit_m;
`ifdef DEMUX_1TO32_SEQ_MASK_EN
   logic [N_CH-1:0]  mask_q, mask_d, src_m;
`endif

   assign ready_o = (state_q == IDLE) || (cnt_q == LAST);
   assign accept  = valid_i && ready_o;

   // Outputs are computed one cycle ahead so the accept edge already presents channel 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      src_w   = shreg_q;
      go      = 1'b0;
`ifdef DEMUX_1TO32_SEQ_MASK_EN
      mask_d  = mask_q;
      src_m   = mask_q;
`endif
      if (accept) begin
         state_d = SEND;
         cnt_d   = '0;
         src_w   = word_i;
`ifdef DEMUX_1TO32_SEQ_MASK_EN
         src_m   = mask_i;
`endif
         go      = 1'b1;
      end else if (state_q == SEND && cnt_q != LAST) begin
         cnt_d   = cnt_q + SEL_W'(1);
         go      = 1'b1;
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
      end

      bit_w = (MSB_FIRST != 0) ? src_w[N_CH-1] : src_w[0];
`ifdef DEMUX_1TO32_SEQ_MASK_EN
      bit_m = src_m[0];
`else
      bit_m = 1'b1;
`endif

      data_d = 1'b0;
      sel_d  = '0;
      en_d   = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      if (go) begin
         data_d  = bit_w & bit_m;
         en_d    = bit_m;
         sel_d   = cnt_d;
         busy_d  = 1'b1;
         done_d  = (cnt_d == LAST);
         shreg_d = (MSB_FIRST != 0) ? (src_w << 1) : (src_w >> 1);
`ifdef DEMUX_1TO32_SEQ_MASK_EN
         mask_d  = src_m >> 1;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         data_q  <= 1'b0;
         sel_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DEMUX_1TO32_SEQ_MASK_EN
         mask_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DEMUX_1TO32_SEQ_MASK_EN
         mask_q  <= mask_d;
`endif
      end
   end

   assign data_o = data_q;
   assign sel_o  = sel_q;
   assign en_o   = en_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_demux_1to32_seq.sv
// Bench for demux_1to32_seq: LSB-first and MSB-first instances share stimulus and
// are checked every cycle against a channel-position model, plus literal directed checks.
module tb_demux_1to32_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] word = '0;
   logic [31:0] mask = '1;
   logic        valid = 1'b0;

   logic       rdy0, dat0, en0, busy0, done0;
   logic [4:0] sel0;
   logic       rdy1, dat1, en1, busy1, done1;
   logic [4:0] sel1;

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   demux_1to32_seq #(.N_CH(32), .SEL_W(5), .MSB_FIRST(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .word_i(word),
`ifdef DEMUX_1TO32_SEQ_MASK_EN
      .mask_i(mask),
`endif
      .valid_i(valid), .ready_o(rdy0), .data_o(dat0), .sel_o(sel0),
      .en_o(en0), .busy_o(busy0), .done_o(done0));

   demux_1to32_seq #(.N_CH(32), .SEL_W(5), .MSB_FIRST(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .word_i(word),
`ifdef DEMUX_1TO32_SEQ_MASK_EN
      .mask_i(mask),
`endif
      .valid_i(valid), .ready_o(rdy1), .data_o(dat1), .sel_o(sel1),
      .en_o(en1), .busy_o(busy1), .done_o(done1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: a word in flight is just "which channel is being driven now".
   logic        m_act = 1'b0;
   int          m_pos = 0;
   logic [31:0] m_word = '0;
   logic [31:0] m_mask = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_act <= 1'b0;
         m_pos <= 0;
      end else if (valid && (!m_act || m_pos == 31)) begin
         m_act  <= 1'b1;
         m_pos  <= 0;
         m_word <= word;
         m_mask <= mask;
      end else if (m_act) begin
         if (m_pos == 31) m_act <= 1'b0;
         else             m_pos <= m_pos + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic       e_rdy, e_en, e_busy, e_done, e_d0, e_d1;
         logic [4:0] e_sel;
         e_rdy  = !m_act || (m_pos == 31);
         e_sel  = m_act ? 5'(m_pos) : 5'd0;
         e_en   = m_act && m_mask[m_pos];
         e_d0   = m_act && m_mask[m_pos] && m_word[m_pos];
         e_d1   = m_act && m_mask[m_pos] && m_word[31 - m_pos];
         e_busy = m_act;
         e_done = m_act && (m_pos == 31);
         chk("m0.ready", 32'(rdy0), 32'(e_rdy));
         chk("m0.sel",   32'(sel0), 32'(e_sel));
         chk("m0.en",    32'(en0),  32'(e_en));
         chk("m0.data",  32'(dat0), 32'(e_d0));
         chk("m0.busy",  32'(busy0), 32'(e_busy));
         chk("m0.done",  32'(done0), 32'(e_done));
         chk("m1.ready", 32'(rdy1), 32'(e_rdy));
         chk("m1.sel",   32'(sel1), 32'(e_sel));
         chk("m1.en",    32'(en1),  32'(e_en));
         chk("m1.data",  32'(dat1), 32'(e_d1));
         chk("m1.busy",  32'(busy1), 32'(e_busy));
         chk("m1.done",  32'(done1), 32'(e_done));
      end
   end

   initial begin
      int cnt;
      // reset and idle
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle.ready", 32'(rdy0), 32'd1);
         chk("idle.en",    32'(en0),  32'd0);
         chk("idle.busy",  32'(busy0), 32'd0);
         chk("idle.done",  32'(done0), 32'd0);
         chk("idle.sel",   32'(sel0), 32'd0);
      end

      // single word 0x1
      word = 32'h0000_0001; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("w1.sel0",  32'(sel0), 32'd0);
      chk("w1.data0", 32'(dat0), 32'd1);
      chk("w1.en0",   32'(en0),  32'd1);
      chk("w1.ready0", 32'(rdy0), 32'd0);
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         chk("w1.sel",  32'(sel0), 32'(k));
         chk("w1.data", 32'(dat0), 32'd0);
         chk("w1.done", 32'(done0), 32'(k == 31));
      end
      @(negedge clk);
      chk("w1.idle_en", 32'(en0), 32'd0);
      chk("w1.idle_done", 32'(done0), 32'd0);

      // back-to-back
      word = 32'hA5A5_A5A5; valid = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (en0) cnt++;
         if (i == 1) chk("b2b.first_data", 32'(dat0), 32'd1);
         if (i == 32) begin
            chk("b2b.sel31", 32'(sel0), 32'd31);
            chk("b2b.done", 32'(done0), 32'd1);
            chk("b2b.ready", 32'(rdy0), 32'd1);
            word = 32'hFFFF_FFFF;
         end
         if (i == 33) begin
            chk("b2b.sel0", 32'(sel0), 32'd0);
            chk("b2b.data", 32'(dat0), 32'd1);
            valid = 1'b0;
         end
      end
      chk("b2b.en_cycles", 32'(cnt), 32'd64);
      @(negedge clk);
      chk("b2b.idle_en", 32'(en0), 32'd0);

      // MSB-first instance
      word = 32'h8000_0000; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("msb.data0", 32'(dat1), 32'd1);
      chk("lsb.data0", 32'(dat0), 32'd0);
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         chk("msb.data", 32'(dat1), 32'd0);
      end
      @(negedge clk);

      // reset abort at sel=10
      word = 32'hFFFF_FFFF; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort.sel10", 32'(sel0), 32'd10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.data",  32'(dat0), 32'd0);
      chk("abort.sel",   32'(sel0), 32'd0);
      chk("abort.en",    32'(en0),  32'd0);
      chk("abort.busy",  32'(busy0), 32'd0);
      chk("abort.ready", 32'(rdy0), 32'd1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done0) cnt++;
      end
      chk("abort.no_done", 32'(cnt), 32'd0);

`ifdef DEMUX_1TO32_SEQ_MASK_EN
      word = 32'hFFFF_FFFF; mask = 32'h0000_00F0; valid = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         valid = 1'b0;
         chk("mask.sel",  32'(sel0), 32'(k));
         chk("mask.en",   32'(en0),  32'(k >= 4 && k <= 7));
         chk("mask.done", 32'(done0), 32'(k == 31));
      end
      @(negedge clk);
      mask = '1;
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         valid = ($urandom_range(0, 3) != 0);
         word  = $urandom;
`ifdef DEMUX_1TO32_SEQ_MASK_EN
         mask  = $urandom;
`endif
         rst   = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      valid = 1'b0; rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
